// File: rtl/apb_spi_slave.sv
// APB-attached SPI target: mode-0, MSB-first 8-bit frames, with all SPI pins
// oversampled into pclk. Software talks through a CSR (0x0) and DATA (0x4).
module apb_spi_slave #(
    parameter int DATA_WIDTH  = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic [2:0]            paddr,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [DATA_WIDTH-1:0] pwdata,
    output logic                  pready,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pslverr,
    input  logic                  sck_i,
    input  logic                  mosi_i,
    input  logic                  ssn_i,
    output logic                  miso_o,
    output logic                  miso_oe_o,
    output logic                  irq_o
);

    typedef enum logic {S_IDLE, S_ACCESS} apb_state_t;

    apb_state_t             r_state;
    logic [SYNC_STAGES-1:0] r_sck_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic [SYNC_STAGES-1:0] r_ssn_sync;
    logic                   r_sck_d;
    logic                   r_ssn_d;
    logic [7:0]             r_shift_rx;
    logic [7:0]             r_shift_tx;
    logic [7:0]             r_rx_data;
    logic [7:0]             r_tx_hold;
    logic [2:0]             r_bitcnt;
    logic                   r_first;
    logic                   r_rx_valid;
    logic                   r_tx_empty;
    logic                   r_rx_ovf;
    logic                   r_tx_under;
    logic                   r_irq_en;
    logic                   r_enable;
    logic                   r_irq;

    logic       w_sck;
    logic       w_mosi;
    logic       w_ssn;
    logic       w_access;
    logic       w_xfer;
    logic       w_addr_ok;
    logic       w_wr_csr;
    logic       w_wr_data;
    logic       w_rd_data;
    logic [7:0] w_csr;
    logic [7:0] w_rdata8;
    logic       w_run;
    logic       w_start;
    logic       w_rise;
    logic       w_fall;
    logic       w_done;
    logic       w_take;
    logic       w_load;
    logic [7:0] w_rx_byte;
    logic       w_unused_pwdata;

    assign w_sck  = r_sck_sync[SYNC_STAGES-1];
    assign w_mosi = r_mosi_sync[SYNC_STAGES-1];
    assign w_ssn  = r_ssn_sync[SYNC_STAGES-1];

    assign w_access  = (r_state == S_ACCESS);
    assign w_xfer    = w_access & psel & penable;
    assign w_addr_ok = (paddr == 3'd0) || (paddr == 3'd4);
    assign w_wr_csr  = w_xfer & pwrite & (paddr == 3'd0);
    assign w_wr_data = w_xfer & pwrite & (paddr == 3'd4);
    assign w_rd_data = w_xfer & ~pwrite & (paddr == 3'd4);

    assign w_csr = {r_enable, 1'b0, r_irq_en, r_tx_under,
                    r_rx_ovf, ~w_ssn, r_tx_empty, r_rx_valid};
    assign w_rdata8 = (paddr == 3'd0) ? w_csr : r_rx_data;

    assign pready  = w_access;
    assign pslverr = w_access & ~w_addr_ok;
    assign prdata  = (w_access & psel & ~pwrite & w_addr_ok)
                   ? {{(DATA_WIDTH-8){1'b0}}, w_rdata8} : '0;

    // Leaving ENABLE or deasserting ssn both mean "no frame in progress".
    assign w_run     = r_enable & ~w_ssn;
    assign w_start   = w_run & r_ssn_d;
    assign w_rise    = w_run & ~w_start & w_sck & ~r_sck_d;
    assign w_fall    = w_run & ~w_start & ~w_sck & r_sck_d;
    assign w_done    = w_rise & (r_bitcnt == 3'd7);
    assign w_take    = w_done & (~r_rx_valid | w_rd_data);
    assign w_load    = w_start | (w_fall & (r_bitcnt == 3'd0) & ~r_first);
    assign w_rx_byte = {r_shift_rx[6:0], w_mosi};

    assign miso_oe_o = r_enable & ~w_ssn;
    assign miso_o    = miso_oe_o & r_shift_tx[7];
    assign irq_o     = r_irq;

    assign w_unused_pwdata = ^{pwdata[DATA_WIDTH-1:8], pwdata[6], pwdata[2:0]};

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_state <= S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE:   if (psel && !penable) r_state <= S_ACCESS;
                S_ACCESS: if (psel && penable)  r_state <= S_IDLE;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_sck_sync  <= '0;
            r_mosi_sync <= '0;
            r_ssn_sync  <= '1;
            r_sck_d     <= 1'b0;
            r_ssn_d     <= 1'b1;
        end else begin
            r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], sck_i};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi_i};
            r_ssn_sync  <= {r_ssn_sync[SYNC_STAGES-2:0], ssn_i};
            r_sck_d     <= w_sck;
            r_ssn_d     <= w_ssn;
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_shift_rx <= '0;
            r_shift_tx <= '0;
            r_rx_data  <= '0;
            r_tx_hold  <= '0;
            r_bitcnt   <= '0;
            r_first    <= 1'b0;
            r_rx_valid <= 1'b0;
            r_tx_empty <= 1'b1;
            r_rx_ovf   <= 1'b0;
            r_tx_under <= 1'b0;
            r_irq_en   <= 1'b0;
            r_enable   <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            if (!w_run) begin
                r_bitcnt   <= '0;
                r_shift_rx <= '0;
            end else if (w_start) begin
                r_bitcnt   <= '0;
                r_shift_rx <= '0;
                r_first    <= 1'b1;
            end else if (w_rise) begin
                r_shift_rx <= w_rx_byte;
                r_bitcnt   <= r_bitcnt + 3'd1;
                r_first    <= 1'b0;
            end else if (w_fall) begin
                r_first <= 1'b0;
                if (r_bitcnt != 3'd0)
                    r_shift_tx <= {r_shift_tx[6:0], 1'b0};
            end

            if (w_load)
                r_shift_tx <= r_tx_empty ? 8'hFF : r_tx_hold;

            // A same-cycle software write wins over the load emptying the holder.
            if (w_wr_data) begin
                r_tx_hold  <= pwdata[7:0];
                r_tx_empty <= 1'b0;
            end else if (w_load && !r_tx_empty) begin
                r_tx_empty <= 1'b1;
            end

            if (w_load && r_tx_empty)
                r_tx_under <= 1'b1;
            else if (w_wr_csr && pwdata[4])
                r_tx_under <= 1'b0;

            if (w_done && !w_take)
                r_rx_ovf <= 1'b1;
            else if (w_wr_csr && pwdata[3])
                r_rx_ovf <= 1'b0;

            if (w_take) begin
                r_rx_data  <= w_rx_byte;
                r_rx_valid <= 1'b1;
            end else if (w_rd_data) begin
                r_rx_valid <= 1'b0;
            end

            if (w_wr_csr) begin
                r_irq_en <= pwdata[5];
                r_enable <= pwdata[7];
            end

            r_irq <= r_irq_en & (r_rx_valid | r_rx_ovf);
        end
    end

endmodule

// File: tb/tb_apb_spi_slave.sv
// Bench for apb_spi_slave: stimulus pushes expectations into queues,
// one monitor process compares APB reads, SPI miso bytes and level probes.
module tb_apb_spi_slave;

    logic        pclk = 1'b0;
    logic        presetn;
    logic [2:0]  paddr;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;
    logic        sck_i;
    logic        mosi_i;
    logic        ssn_i;
    logic        miso_o;
    logic        miso_oe_o;
    logic        irq_o;

    apb_spi_slave #(.DATA_WIDTH(32), .SYNC_STAGES(2)) dut (
        .pclk(pclk), .presetn(presetn), .paddr(paddr), .psel(psel),
        .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
        .pready(pready), .prdata(prdata), .pslverr(pslverr),
        .sck_i(sck_i), .mosi_i(mosi_i), .ssn_i(ssn_i),
        .miso_o(miso_o), .miso_oe_o(miso_oe_o), .irq_o(irq_o)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        logic [31:0] d;
        logic        err;
        string       name;
    } apb_exp_t;

    typedef struct {
        int          kind;
        logic [31:0] exp;
        string       name;
    } probe_t;

    apb_exp_t apb_q[$];
    probe_t   probe_q[$];
    logic [7:0] miso_q[$];

    int   nchk = 0;
    int   nerr = 0;
    bit   fin = 1'b0;
    bit   fin_done = 1'b0;
    logic sck_prev = 1'b0;
    int   bcnt = 0;
    logic [7:0] sh = '0;

    function automatic logic [31:0] probe_val(int k);
        case (k)
            0: probe_val = {31'b0, pready};
            1: probe_val = prdata;
            2: probe_val = {31'b0, pslverr};
            3: probe_val = {31'b0, miso_o};
            4: probe_val = {31'b0, miso_oe_o};
            default: probe_val = {31'b0, irq_o};
        endcase
    endfunction

    always @(negedge pclk) begin
        if (psel && penable && pready && !pwrite) begin
            nchk++;
            if (apb_q.size() == 0) begin
                nerr++;
                $display("FAIL apb_unexpected_read got=%h", prdata);
            end else begin
                apb_exp_t a;
                a = apb_q.pop_front();
                if (prdata !== a.d || pslverr !== a.err) begin
                    nerr++;
                    $display("FAIL %s got=%h/%b want=%h/%b",
                             a.name, prdata, pslverr, a.d, a.err);
                end
            end
        end
        while (probe_q.size() > 0) begin
            probe_t p;
            logic [31:0] v;
            p = probe_q.pop_front();
            v = probe_val(p.kind);
            nchk++;
            if (v !== p.exp) begin
                nerr++;
                $display("FAIL %s got=%h want=%h", p.name, v, p.exp);
            end
        end
        if (ssn_i) begin
            bcnt = 0;
        end else if (sck_i && !sck_prev) begin
            sh = {sh[6:0], miso_o};
            bcnt++;
            if (bcnt == 8) begin
                bcnt = 0;
                nchk++;
                if (miso_q.size() == 0) begin
                    nerr++;
                    $display("FAIL miso_unexpected_byte got=%h", sh);
                end else begin
                    logic [7:0] e;
                    e = miso_q.pop_front();
                    if (sh !== e) begin
                        nerr++;
                        $display("FAIL miso_byte got=%h want=%h", sh, e);
                    end
                end
            end
        end
        sck_prev = sck_i;
        if (fin && !fin_done) begin
            fin_done = 1'b1;
            nchk++;
            if (apb_q.size() != 0 || miso_q.size() != 0) begin
                nerr++;
                $display("FAIL leftover_expect got=%0d/%0d want=0/0",
                         apb_q.size(), miso_q.size());
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge pclk);
        #1;
    endtask

    task automatic probe(input int k, input logic [31:0] e, input string nm);
        probe_t p;
        p.kind = k;
        p.exp  = e;
        p.name = nm;
        probe_q.push_back(p);
    endtask

    task automatic apb_write(input logic [2:0] a, input logic [31:0] d);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
        tick(1);
        penable = 1'b1;
        tick(1);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [2:0] a, input logic [31:0] e,
                            input string nm);
        apb_exp_t x;
        x.d    = e;
        x.err  = (a != 3'd0) && (a != 3'd4);
        x.name = nm;
        apb_q.push_back(x);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
        tick(1);
        penable = 1'b1;
        tick(1);
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic spi_frame(input logic [7:0] b, input int nbits,
                             input logic oe_exp, input bit hold);
        ssn_i = 1'b0;
        tick(8);
        probe(4, {31'b0, oe_exp}, "miso_oe_in_frame");
        for (int i = 0; i < nbits; i++) begin
            mosi_i = b[7-i];
            tick(4);
            sck_i = 1'b1;
            tick(4);
            sck_i = 1'b0;
        end
        if (!hold) begin
            tick(4);
            ssn_i = 1'b1;
            tick(8);
        end
    endtask

    initial begin
        presetn = 1'b0;
        paddr = '0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; pwdata = '0;
        sck_i = 1'b0; mosi_i = 1'b0; ssn_i = 1'b1;
        tick(2);
        probe(0, 0, "rst_pready");
        probe(1, 0, "rst_prdata");
        probe(2, 0, "rst_pslverr");
        probe(3, 0, "rst_miso");
        probe(4, 0, "rst_miso_oe");
        probe(5, 0, "rst_irq");
        tick(2);
        presetn = 1'b1;
        tick(4);
        apb_read(3'd0, 32'h02, "csr_reset");

        apb_write(3'd0, 32'h80);
        apb_write(3'd4, 32'hA5);
        miso_q.push_back(8'hA5);
        spi_frame(8'h3C, 8, 1'b1, 1'b0);
        apb_read(3'd0, 32'h93, "csr_after_3c");
        apb_read(3'd4, 32'h3C, "data_3c");
        apb_read(3'd0, 32'h92, "csr_rx_cleared");
        apb_write(3'd0, 32'h90);
        apb_read(3'd0, 32'h82, "csr_under_w1c");

        miso_q.push_back(8'hFF);
        spi_frame(8'h77, 8, 1'b1, 1'b0);
        apb_read(3'd0, 32'h93, "csr_underrun");
        apb_write(3'd0, 32'h90);
        apb_read(3'd0, 32'h83, "csr_under_clr_en_kept");
        apb_read(3'd4, 32'h77, "data_77");
        apb_read(3'd0, 32'h82, "csr_idle2");

        apb_write(3'd0, 32'hA0);
        tick(2);
        probe(5, 0, "irq_idle");
        miso_q.push_back(8'hFF);
        spi_frame(8'h11, 8, 1'b1, 1'b0);
        miso_q.push_back(8'hFF);
        spi_frame(8'h22, 8, 1'b1, 1'b0);
        apb_read(3'd0, 32'hBB, "csr_overflow");
        probe(5, 1, "irq_ovf");
        apb_write(3'd0, 32'hB8);
        tick(3);
        probe(5, 1, "irq_rx_valid_only");
        apb_read(3'd4, 32'h11, "data_first_kept");
        tick(3);
        probe(5, 0, "irq_cleared");
        apb_read(3'd0, 32'hA2, "csr_after_ovf");
        apb_write(3'd0, 32'h80);

        spi_frame(8'hF0, 4, 1'b1, 1'b0);
        miso_q.push_back(8'hFF);
        spi_frame(8'h5A, 8, 1'b1, 1'b0);
        apb_read(3'd0, 32'h93, "csr_after_abort");
        apb_read(3'd4, 32'h5A, "data_5a");
        apb_read(3'd0, 32'h92, "csr_single_byte");
        apb_write(3'd0, 32'h90);

        apb_read(3'd2, 32'h0, "bad_addr_read");
        apb_write(3'd6, 32'hFF);
        apb_read(3'd0, 32'h82, "csr_bad_write_ignored");
        apb_write(3'd0, 32'h00);
        apb_read(3'd0, 32'h02, "csr_disabled");
        miso_q.push_back(8'h00);
        spi_frame(8'h99, 8, 1'b0, 1'b0);
        apb_read(3'd0, 32'h02, "csr_disabled_frame");

        apb_write(3'd0, 32'h80);
        spi_frame(8'hAA, 4, 1'b1, 1'b1);
        presetn = 1'b0;
        tick(1);
        probe(4, 0, "midrst_miso_oe");
        probe(3, 0, "midrst_miso");
        probe(5, 0, "midrst_irq");
        ssn_i = 1'b1;
        sck_i = 1'b0;
        tick(3);
        presetn = 1'b1;
        tick(4);
        apb_read(3'd0, 32'h02, "csr_after_reset");
        apb_write(3'd0, 32'h80);
        miso_q.push_back(8'hFF);
        spi_frame(8'hC3, 8, 1'b1, 1'b0);
        apb_read(3'd0, 32'h93, "csr_c3");
        apb_read(3'd4, 32'hC3, "data_c3");

        tick(2);
        fin = 1'b1;
        tick(3);
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule

// File: doc/apb_spi_slave.md
Name: apb_spi_slave

Overview:
- APB-attached SPI target (slave) for SvarogSoC: the opposite end of the existing APB SPI master.
- Receives mode-0, MSB-first 8-bit frames from an external master and returns bytes from a TX holding register.
- All SPI pins are oversampled and synchronised into pclk; there is no separate SPI clock domain.
- Software exchanges data through a CSR and a DATA register.

Parameters:
- DATA_WIDTH, 32, APB data width; only bits [7:0] are used.
- SYNC_STAGES, 2, synchroniser depth for sck_i, mosi_i and ssn_i (minimum 2).

Ports:
- pclk  in  1  APB and core clock.
- presetn  in  1  asynchronous active-low reset.
- paddr  in  3  0 = CSR, 4 = DATA.
- psel  in  1  APB select.
- penable  in  1  APB enable.
- pwrite  in  1  APB write.
- pwdata  in  DATA_WIDTH  write data.
- pready  out  1  transfer ready.
- prdata  out  DATA_WIDTH  read data, zero-extended from 8 bits.
- pslverr  out  1  error for an unmapped address.
- sck_i  in  1  SPI clock from the master.
- mosi_i  in  1  serial data in.
- ssn_i  in  1  active-low select.
- miso_o  out  1  serial data out.
- miso_oe_o  out  1  pad output enable for miso_o.
- irq_o  out  1  level interrupt.

Behaviour:
- Reset presetn, asynchronous, active-low; clock pclk.
- Reset values:
  - All outputs 0.
  - CSR = 0x02 (TX_EMPTY=1).
  - Shift registers, bit counter and RX/TX data registers 0.
  - Synchronisers: sck and mosi stages reset to 0, ssn stages reset to 1.
- APB protocol:
  - FSM states IDLE and ACCESS.
  - IDLE→ACCESS on psel & !penable; ACCESS→IDLE on psel & penable.
  - pready=1 only in ACCESS, giving zero wait states.
  - prdata is valid in ACCESS for reads and is 0 otherwise.
  - pslverr=1 in ACCESS when paddr is not 0 or 4; such writes have no effect.
- CSR bits:
  - [0] RX_VALID, read-only.
  - [1] TX_EMPTY, read-only.
  - [2] BUSY, read-only; equals the synchronised ssn being low.
  - [3] RX_OVF, write-1-to-clear.
  - [4] TX_UNDER, write-1-to-clear.
  - [5] IRQ_EN, read/write.
  - [6] reserved, reads 0.
  - [7] ENABLE, read/write.
- DATA register:
  - A read returns RX data and clears RX_VALID.
  - A write loads the TX holding register and clears TX_EMPTY.
  - A write while the holding register is full overwrites it (last write wins).
- SPI engine (active only when ENABLE=1):
  - Edges are detected on the synchronised sck and ssn.
  - Required sck ≤ pclk/8.
- Start of frame (ssn falling):
  - bitcnt=0.
  - If TX is full: shift_tx is loaded from the holding register and TX_EMPTY is set to 1.
  - If TX is empty: shift_tx is loaded with 0xFF and TX_UNDER is set to 1.
  - miso_o = shift_tx[7].
- sck rising: shift_rx = {shift_rx[6:0], mosi_sync}; bitcnt increments.
- Byte completion (8th rising edge):
  - If RX_VALID=0: RX data is updated and RX_VALID is set.
  - If RX_VALID=1: the new byte is dropped, RX data is kept, and RX_OVF is set.
  - bitcnt wraps to 0.
- sck falling:
  - If bitcnt≠0: shift_tx shifts left by one.
  - If bitcnt=0 and this is not the first edge of the frame: the next byte is loaded from TX using the same full/empty rules as start of frame.
  - miso_o = shift_tx[7].
- ssn rising mid-byte: the partial byte is discarded, bitcnt=0, and RX is not updated.
- miso_oe_o = ENABLE & ~ssn_sync. miso_o = 0 whenever miso_oe_o = 0.
- ENABLE=0:
  - SPI edges are ignored and bitcnt is held at 0.
  - The APB registers remain accessible.
  - Clearing ENABLE mid-frame aborts the frame, the same as an ssn rising edge.
- Simultaneous events:
  - DATA read in the same cycle as byte completion: the new byte is stored, RX_VALID stays 1, and no overflow is flagged.
  - TX write in the same cycle as a shift_tx load: the load takes the old holding value, the holding register takes the new value, and TX_EMPTY=0.
  - W1C in the same cycle as a hardware set: the set wins.
- irq_o = IRQ_EN & (RX_VALID | RX_OVF), registered; it follows the flags with a latency of 1 pclk.
- Latency: RX_VALID is set within SYNC_STAGES+2 pclk of the 8th sck rising edge at the pin.
- Reset mid-frame: all state returns to its reset values immediately. The next valid frame starts at the next ssn falling edge seen after reset is released.

Test Plan:
- Write CSR=0x80 and DATA=0xA5; master sends 0x3C with sck = pclk/8 → miso bits 1,0,1,0,0,1,0,1; RX_VALID=1; DATA read=0x3C; RX_VALID clears; TX_EMPTY=1.
- No DATA write, master sends 1 byte → miso 0xFF; CSR TX_UNDER=1; write CSR 0x90 → TX_UNDER=0, ENABLE stays set.
- Two bytes 0x11 then 0x22 with no read in between → DATA=0x11, RX_OVF=1; with IRQ_EN=1, irq_o=1 until RX_OVF is cleared and DATA is read.
- ssn raised after 4 sck edges, then a full byte 0x5A → RX_VALID=1 only once, DATA=0x5A.
- APB read at paddr=2 → pready=1, pslverr=1, prdata=0; write to CSR with ENABLE=0, then a frame → no flag changes, miso_oe_o=0.
- presetn asserted mid-byte → CSR=0x02, miso_oe_o=0; the next full frame 0xC3 is received correctly.
